// File: rtl/popcount_rr_scheduler.sv
// popcount_rr_scheduler
// Round-robin front end that shares one bit_population_counter pipeline
// between NUM_REQ requesters. A registered issue stage feeds the pipeline,
// an in-order tag FIFO remembers which requester owns each word in flight,
// and a registered result stage pairs every returning count with its tag.
// Optional build macro: POPCOUNT_RR_SCHEDULER_ERR_EN adds a sticky err_o
// that flags a pipeline result arriving while no word is outstanding.

module popcount_rr_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int WIDTH           = 32,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CW  = $clog2(WIDTH) + 1,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     srst_n_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]       req_val_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]         pc_data_o,
  output logic                     pc_data_val_o,
  input  logic [CW-1:0]            pc_data_i,
  input  logic                     pc_data_val_i,
  output logic [CW-1:0]            res_data_o,
  output logic [IDW-1:0]           res_id_o,
  output logic                     res_val_o,
`ifdef POPCOUNT_RR_SCHEDULER_ERR_EN
  output logic                     err_o,
`endif
  output logic                     busy_o
);

  // Tag FIFO pointer width, outstanding counter width (must hold the value
  // MAX_OUTSTANDING itself) and a one-bit-wider index for the wrap search.
  localparam int             PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int             OCW      = $clog2(MAX_OUTSTANDING + 1);
  localparam int             IDW1     = IDW + 1;
  localparam logic [OCW-1:0] MAX_CNT  = OCW'(MAX_OUTSTANDING);
  localparam logic [IDW:0]   NREQ_EXT = IDW1'(NUM_REQ);
  localparam logic [IDW-1:0] PTR_INIT = IDW'(NUM_REQ - 1);

  // Arbitration
  logic [IDW-1:0]   rrPtr_q;
  logic [IDW-1:0]   rrPtr_d;
  logic [IDW:0]     candIdx;
  logic             grantFound;
  logic [IDW-1:0]   grantIdx;
  logic             canIssue;
  logic             grant;
  logic [WIDTH-1:0] grantWord;

  // Issue stage
  logic [WIDTH-1:0] pcData_q;
  logic [WIDTH-1:0] pcData_d;
  logic             pcDataVal_q;
  logic             pcDataVal_d;

  // Tag FIFO and outstanding bookkeeping
  logic [IDW-1:0]   tagMem_q [MAX_OUTSTANDING];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    wrPtr_d;
  logic [PW-1:0]    rdPtr_q;
  logic [PW-1:0]    rdPtr_d;
  logic [OCW-1:0]   outstanding_q;
  logic [OCW-1:0]   outstanding_d;
  logic             fifoEmpty;
  logic             pop;

  // Result stage
  logic [CW-1:0]    resData_q;
  logic [CW-1:0]    resData_d;
  logic [IDW-1:0]   resId_q;
  logic [IDW-1:0]   resId_d;
  logic             resVal_q;
  logic             resVal_d;

`ifdef POPCOUNT_RR_SCHEDULER_ERR_EN
  logic             errFlag_q;
  logic             errFlag_d;
`endif

  // Outstanding count already includes the word sitting in the issue stage,
  // so a full FIFO blocks new grants even if a result pops this same cycle.
  assign canIssue  = (outstanding_q < MAX_CNT);
  assign fifoEmpty = (outstanding_q == '0);
  assign pop       = pc_data_val_i && !fifoEmpty;
  assign grant     = srst_n_i && canIssue && grantFound;
  assign grantWord = req_data_i[grantIdx*WIDTH +: WIDTH];

  // Round-robin search starting one past the last winner, wrapping modulo NUM_REQ
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    candIdx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      candIdx = {1'b0, rrPtr_q} + IDW1'(i);
      if (candIdx >= NREQ_EXT) begin
        candIdx = candIdx - NREQ_EXT;
      end
      if (!grantFound && req_val_i[candIdx[IDW-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = candIdx[IDW-1:0];
      end
    end
  end

  // Ready is one-hot on the winner, or all zero when nothing may issue
  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[grantIdx] = 1'b1;
    end
  end

  // Next-state for pointer, issue stage and FIFO pointers
  always_comb begin
    rrPtr_d     = rrPtr_q;
    pcData_d    = pcData_q;
    pcDataVal_d = grant;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    if (grant) begin
      rrPtr_d  = grantIdx;
      pcData_d = grantWord;
      wrPtr_d  = wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
  end

  // Outstanding counter: simultaneous grant and pop cancel out; an orphan
  // result on an empty FIFO never decrements, so the counter cannot wrap
  always_comb begin
    outstanding_d = outstanding_q;
    if (grant && !pop) begin
      outstanding_d = outstanding_q + OCW'(1);
    end else if (!grant && pop) begin
      outstanding_d = outstanding_q - OCW'(1);
    end
  end

  // Result stage pairs the count with the oldest tag; orphans are dropped
  always_comb begin
    resVal_d  = pop;
    resData_d = resData_q;
    resId_d   = resId_q;
    if (pop) begin
      resData_d = pc_data_i;
      resId_d   = tagMem_q[rdPtr_q];
    end
  end

`ifdef POPCOUNT_RR_SCHEDULER_ERR_EN
  // Sticky flag for a result that arrives with nothing outstanding
  always_comb begin
    errFlag_d = errFlag_q | (pc_data_val_i && fifoEmpty);
  end
`endif

  // Tag storage needs no reset: occupancy is tracked by the pointers and counter
  always_ff @(posedge clk_i) begin
    if (grant) begin
      tagMem_q[wrPtr_q] <= grantIdx;
    end
  end

  // Control and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      rrPtr_q       <= PTR_INIT;
      pcData_q      <= '0;
      pcDataVal_q   <= 1'b0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      outstanding_q <= '0;
      resData_q     <= '0;
      resId_q       <= '0;
      resVal_q      <= 1'b0;
    end else begin
      rrPtr_q       <= rrPtr_d;
      pcData_q      <= pcData_d;
      pcDataVal_q   <= pcDataVal_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      outstanding_q <= outstanding_d;
      resData_q     <= resData_d;
      resId_q       <= resId_d;
      resVal_q      <= resVal_d;
    end
  end

`ifdef POPCOUNT_RR_SCHEDULER_ERR_EN
  // Error flag clears only on reset
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      errFlag_q <= 1'b0;
    end else begin
      errFlag_q <= errFlag_d;
    end
  end

  assign err_o = errFlag_q;
`endif

  assign pc_data_o     = pcData_q;
  assign pc_data_val_o = pcDataVal_q;
  assign res_data_o    = resData_q;
  assign res_id_o      = resId_q;
  assign res_val_o     = resVal_q;
  assign busy_o        = !fifoEmpty;

endmodule

// File: doc/popcount_rr_scheduler.md
Name: popcount_rr_scheduler

Overview:
Round-robin scheduler that shares one bit_population_counter pipeline between NUM_REQ requesters. It grants at most one request per cycle and drives the pipeline's data/valid inputs from a registered issue stage. It tags each issued word with the requester index in an in-order tag FIFO. It pairs each pipeline result with the oldest tag and presents the count plus requester ID on a single result port.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 32, data word width; must match the pipeline's WIDTH
MAX_OUTSTANDING, 8, tag FIFO depth = max words in flight (power of 2, >= pipeline latency+1 for full throughput)

Ports:
clk_i  input  1  clock
srst_n_i  input  1  synchronous reset, active-low
req_data_i  input  NUM_REQ*WIDTH  packed request words, requester k at [k*WIDTH +: WIDTH]
req_val_i  input  NUM_REQ  per-requester valid
req_ready_o  output  NUM_REQ  per-requester ready (one-hot or zero)
pc_data_o  output  WIDTH  word to pipeline data_i
pc_data_val_o  output  1  to pipeline data_val_i
pc_data_i  input  $clog2(WIDTH)+1  pipeline data_o
pc_data_val_i  input  1  pipeline data_val_o
res_data_o  output  $clog2(WIDTH)+1  popcount result
res_id_o  output  max(1,$clog2(NUM_REQ))  requester index of result
res_val_o  output  1  result valid, one cycle, no backpressure
busy_o  output  1  outstanding count != 0

Behaviour:
- Reset (srst_n_i=0 at posedge): pc_data_val_o=0, pc_data_o=0, res_val_o=0, res_data_o=0, res_id_o=0, busy_o=0. Outstanding count=0, tag FIFO empty, RR pointer=NUM_REQ-1 so requester 0 has first priority. req_ready_o is forced to 0 while srst_n_i=0.
- Handshake: a transfer from requester k occurs when req_val_i[k] && req_ready_o[k]. req_ready_o is combinational from req_val_i, the RR pointer and the can_issue condition. req_val_i must not depend on req_ready_o.
- can_issue = outstanding < MAX_OUTSTANDING, where outstanding already counts the issue-stage word.
- Arbitration: search starts at pointer+1 and wraps modulo NUM_REQ. The first valid requester is granted only if can_issue. On a grant the pointer updates to the granted index; with no grant it holds.
- Issue stage: on a grant, the next cycle has pc_data_o=granted word and pc_data_val_o=1, and the granted index is pushed to the tag FIFO. With no grant, pc_data_val_o=0 and pc_data_o holds its previous value.
- Throughput: one issue per cycle while requests are pending and can_issue holds.
- Outstanding counter:
  - +1 on grant, -1 on pc_data_val_i.
  - Both in the same cycle: unchanged.
  - Never wraps, because grants are blocked at MAX_OUTSTANDING.
- Result stage (1 cycle registered): on pc_data_val_i, res_data_o=pc_data_i, res_id_o=FIFO head, res_val_o=1, and the head is popped. Otherwise res_val_o=0 and the data/ID registers hold.
- Latency: request handshake to pc_data_val_o is 1 cycle. pc_data_val_i to res_val_o is 1 cycle. End to end = pipeline latency + 2.
- Ordering: results return in issue order. The pipeline is in-order, and the FIFO relies on that.
- Full FIFO with a simultaneous pop: no grant that cycle; granting resumes the next cycle.
- Empty FIFO with pc_data_val_i: the result is dropped (res_val_o stays 0) and the counter stays at 0.
- Reset mid-operation: all in-flight tags are discarded. The pipeline must share the same reset, with polarity adapted at instantiation. Any stray result after reset is dropped per the empty-FIFO rule.

Optional Feature:
POPCOUNT_RR_SCHEDULER_ERR_EN:
- Defined: adds output err_o (1 bit), reset 0. It is set sticky on pc_data_val_i while the tag FIFO is empty, and cleared only by reset.
- Undefined: no err_o port; the orphan result is silently dropped.

Test Plan:
- Single requester: req 0 sends 32'hFFFF_0000 → pc_data_val_o 1 cycle later; result 16 with res_id_o=0, pipeline latency+2 cycles after the handshake.
- All 4 requesters hold valid continuously (words 32'h1, 32'h3, 32'h7, 32'hF) → grants 0,1,2,3,0,… every cycle; results 1,2,3,4 repeat with IDs 0,1,2,3 in order.
- Stall the pipeline result (bench model delays pc_data_val_i) with MAX_OUTSTANDING=8 → exactly 8 grants, then req_ready_o=0. The first result releases exactly one further grant.
- Requesters 1 and 3 only, alternating data 32'h0 / 32'hFFFF_FFFF → grants alternate 1,3; results 0 (ID 1) and 32 (ID 3); requesters 0 and 2 are never granted.
- Reset asserted with 5 words in flight → next cycle all outputs 0 and busy_o=0; the following request is granted to requester 0 first.
- ERR_EN build: inject pc_data_val_i with empty FIFO → err_o=1 and stays set; res_val_o stays 0.
